// File: rtl/i2c_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_regs
// Summary  : Oversampled I2C target with a 2**ADDR_W byte register file.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h3A,
  parameter int         ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_o,
  output logic              busy,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] loc_raddr,
  output logic [7:0]        loc_rdata
);

  localparam int                c_NREGS   = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] c_PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_REG       = 4'd3,
    S_REG_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RDATA_ACK = 4'd8,
    S_IGNORE    = 4'd9
  } state_t;

  logic r_scl_s1, r_scl_s2, r_scl_d;
  logic r_sda_s1, r_sda_s2, r_sda_d;

  state_t            r_state;
  logic [3:0]        r_bitcnt;
  logic [7:0]        r_shift;
  logic [6:0]        r_tx;
  logic [ADDR_W-1:0] r_ptr;
  logic [7:0]        r_regs [c_NREGS];
  logic              r_sda_o;
  logic              r_busy;
  logic              r_wr_strobe;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic       w_rx_state, w_byte_done, w_addr_match;
  logic [7:0] w_rd_byte;

  // Idle bus is high, so the synchronizers reset high to avoid a false edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= scl_i;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_i;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  assign w_scl_rise   = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall   = ~r_scl_s2 & r_scl_d;
  assign w_start      = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop       = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;

  assign w_rx_state   = (r_state == S_ADDR) || (r_state == S_REG) || (r_state == S_WDATA);
  assign w_byte_done  = (r_bitcnt == 4'd8);
  assign w_addr_match = (r_shift[7:1] == SLAVE_ADDR);
  assign w_rd_byte    = r_regs[r_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_bitcnt    <= 4'd0;
      r_shift     <= 8'h00;
      r_tx        <= 7'h00;
      r_ptr       <= '0;
      r_sda_o     <= 1'b1;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= 8'h00;
      for (int i = 0; i < c_NREGS; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_start) begin
        r_state  <= S_ADDR;
        r_bitcnt <= 4'd0;
        r_sda_o  <= 1'b1;
      end else if (w_stop) begin
        r_state  <= S_IDLE;
        r_bitcnt <= 4'd0;
        r_sda_o  <= 1'b1;
        r_busy   <= 1'b0;
      end else if (w_scl_rise) begin
        if (w_rx_state && !w_byte_done) begin
          r_shift  <= {r_shift[6:0], r_sda_s2};
          r_bitcnt <= r_bitcnt + 4'd1;
        end else if (r_state == S_RDATA_ACK) begin
          if (r_sda_s2) begin
            r_state <= S_IGNORE;
            r_busy  <= 1'b0;
          end else begin
            // Remember the master ACK; the next byte is loaded on the coming fall.
            r_bitcnt <= 4'd8;
          end
        end
      end else if (w_scl_fall) begin
        case (r_state)
          S_ADDR: begin
            if (w_byte_done) begin
              r_bitcnt <= 4'd0;
              if (w_addr_match) begin
                r_sda_o <= 1'b0;
                r_busy  <= 1'b1;
                r_state <= S_ADDR_ACK;
              end else begin
                r_busy  <= 1'b0;
                r_state <= S_IGNORE;
              end
            end
          end
          S_ADDR_ACK: begin
            if (r_shift[0]) begin
              r_tx     <= w_rd_byte[6:0];
              r_sda_o  <= w_rd_byte[7];
              r_ptr    <= r_ptr + c_PTR_ONE;
              r_bitcnt <= 4'd0;
              r_state  <= S_RDATA;
            end else begin
              r_sda_o  <= 1'b1;
              r_state  <= S_REG;
            end
          end
          S_REG: begin
            if (w_byte_done) begin
              r_bitcnt <= 4'd0;
              r_sda_o  <= 1'b0;
              r_ptr    <= r_shift[ADDR_W-1:0];
              r_state  <= S_REG_ACK;
            end
          end
          S_WDATA: begin
            if (w_byte_done) begin
              r_bitcnt       <= 4'd0;
              r_sda_o        <= 1'b0;
              r_regs[r_ptr]  <= r_shift;
              r_wr_strobe    <= 1'b1;
              r_wr_addr      <= r_ptr;
              r_wr_data      <= r_shift;
              r_ptr          <= r_ptr + c_PTR_ONE;
              r_state        <= S_WDATA_ACK;
            end
          end
          S_REG_ACK, S_WDATA_ACK: begin
            r_sda_o <= 1'b1;
            r_state <= S_WDATA;
          end
          S_RDATA: begin
            if (r_bitcnt == 4'd7) begin
              r_sda_o  <= 1'b1;
              r_bitcnt <= 4'd0;
              r_state  <= S_RDATA_ACK;
            end else begin
              r_sda_o  <= r_tx[6];
              r_tx     <= {r_tx[5:0], 1'b0};
              r_bitcnt <= r_bitcnt + 4'd1;
            end
          end
          S_RDATA_ACK: begin
            if (w_byte_done) begin
              r_tx     <= w_rd_byte[6:0];
              r_sda_o  <= w_rd_byte[7];
              r_ptr    <= r_ptr + c_PTR_ONE;
              r_bitcnt <= 4'd0;
              r_state  <= S_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_o     = r_sda_o;
  assign busy      = r_busy;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign loc_rdata = r_regs[loc_raddr];

endmodule
`default_nettype wire
